spi_io: RTL and testbench

//  SPI slave (mode 0: CPOL=0, CPHA=0, MSB first, CS active-low) word transceiver.

---
 rtl/spi_io.sv | 106 ++++++++++
 tb/tb_spi_io.sv | 130 +++++++++++++
 2 files changed

// File: rtl/spi_io.sv
// SPI mode-0 slave word transceiver; all SPI pins are synchronised and sampled on clk.
// Receives IN_WIDTH-bit words on mosi into rx_data and shifts tx_data out on miso, MSB first.
module spi_io #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sclk,
  input  logic                 cs,
  output logic                 miso,
  input  logic                 mosi,
  output logic [IN_WIDTH-1:0]  rx_data,
  input  logic [OUT_WIDTH-1:0] tx_data,
  output logic                 rx_valid
);

  localparam int CW = $clog2(IN_WIDTH + 1);

  typedef enum logic {ST_IDLE, ST_FRAME} state_t;

  state_t               r_state, w_next;
  logic [2:0]           r_sclk_p, r_cs_p, r_flush;
  logic [1:0]           r_mosi_p;
  logic [CW-1:0]        r_cnt;
  logic [IN_WIDTH-1:0]  r_rx_shift;
  logic [OUT_WIDTH-1:0] r_tx_shift;
  logic [IN_WIDTH-1:0]  w_rx_next;
  logic                 w_ok, w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_p <= '0;
      r_cs_p   <= '1;
      r_mosi_p <= '0;
      r_flush  <= '0;
    end else begin
      r_sclk_p <= {r_sclk_p[1:0], sclk};
      r_cs_p   <= {r_cs_p[1:0], cs};
      r_mosi_p <= {r_mosi_p[0], mosi};
      r_flush  <= {r_flush[1:0], 1'b1};
    end
  end

  // Edges are masked until the pipelines hold real pin values, so a cs held
  // low across reset is not mistaken for a falling edge of the reset value.
  assign w_ok        = r_flush[2];
  assign w_sclk_rise = w_ok &  r_sclk_p[1] & ~r_sclk_p[2];
  assign w_sclk_fall = w_ok & ~r_sclk_p[1] &  r_sclk_p[2];
  assign w_cs_fall   = w_ok & ~r_cs_p[1]   &  r_cs_p[2];
  assign w_cs_rise   = w_ok &  r_cs_p[1]   & ~r_cs_p[2];
  assign w_rx_next   = {r_rx_shift[IN_WIDTH-2:0], r_mosi_p[1]};

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_cs_fall) w_next = ST_FRAME;
      ST_FRAME: if (w_cs_rise) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_shift <= '0;
      r_tx_shift <= '0;
      r_cnt      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (w_cs_fall) begin
          r_tx_shift <= tx_data;
          r_rx_shift <= '0;
          r_cnt      <= '0;
        end
      end else if (w_cs_rise) begin
        r_tx_shift <= '0;
        r_rx_shift <= '0;
        r_cnt      <= '0;
      end else if (w_sclk_rise) begin
        r_rx_shift <= w_rx_next;
        if (r_cnt == CW'(IN_WIDTH - 1)) begin
          rx_data  <= w_rx_next;
          rx_valid <= 1'b1;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else if (w_sclk_fall) begin
        // A falling edge with the counter at 0 follows a word wrap: present the next word's MSB.
        if (r_cnt == '0) r_tx_shift <= tx_data;
        else             r_tx_shift <= {r_tx_shift[OUT_WIDTH-2:0], 1'b0};
      end
    end
  end

  assign miso = r_tx_shift[OUT_WIDTH-1];

endmodule

// File: tb/tb_spi_io.sv
// Directed plus randomized bench for spi_io with tx_data tied to ~rx_data (loopback complementer).
`timescale 1ns/1ps
module tb_spi_io;

  logic        clk = 1'b0;
  logic        rst, sclk, cs, mosi, miso, rx_valid;
  logic [15:0] rx_data, tx_data;

  int          errors = 0;
  int          checks = 0;
  int          vcnt   = 0;
  logic [15:0] m_rx;

  spi_io #(.IN_WIDTH(16), .OUT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .miso(miso), .mosi(mosi),
    .rx_data(rx_data), .tx_data(tx_data), .rx_valid(rx_valid)
  );

  always #5 clk = ~clk;
  assign tx_data = ~rx_data;

  always @(posedge clk) if (rx_valid === 1'b1) vcnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Master side: set mosi, raise sclk and sample miso, lower sclk.
  task automatic xfer(input logic [15:0] w, input int nbits, output logic [15:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = w[15-i];
      #60 sclk = 1'b1;
      got = {got[14:0], miso};
      #60 sclk = 1'b0;
    end
  endtask

  // Reference: each word sent back is the complement of the word received just before it.
  task automatic frame(input logic [15:0] w0, input logic [15:0] w1, input int nw, input string tag);
    logic [15:0] got, exp_tx;
    int v0;
    v0 = vcnt;
    exp_tx = ~m_rx;
    cs = 1'b0;
    #100;
    xfer(w0, 16, got);
    check({tag, " miso w0"}, got, exp_tx);
    m_rx = w0;
    exp_tx = ~w0;
    if (nw == 2) begin
      xfer(w1, 16, got);
      check({tag, " miso w1"}, got, exp_tx);
      m_rx = w1;
    end
    #60 cs = 1'b1;
    #100;
    check({tag, " rx_data"}, rx_data, m_rx);
    check({tag, " rx_valid count"}, vcnt - v0, nw);
    check({tag, " miso idle"}, miso, 1'b0);
  endtask

  initial begin
    logic [15:0] got;
    int v0, nw;
    rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; m_rx = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset rx_data", rx_data, 0);
    check("reset miso", miso, 0);
    check("reset rx_valid", rx_valid, 0);
    #100;

    frame(16'h1234, 16'h0000, 1, "frame1");
    frame(16'hA5A5, 16'h0000, 1, "frame2");

    v0 = vcnt;
    cs = 1'b0;
    #100;
    xfer(16'hFFFF, 7, got);
    #60 cs = 1'b1;
    #100;
    check("abort rx_data", rx_data, m_rx);
    check("abort rx_valid count", vcnt - v0, 0);
    check("abort miso", miso, 0);

    frame(16'h0001, 16'h8000, 2, "twoword");

    v0 = vcnt;
    for (int i = 0; i < 8; i++) begin
      mosi = 1'($urandom);
      sclk = 1'b1;
      #60 check("idle sclk miso", miso, 0);
      sclk = 1'b0;
      #60;
    end
    check("idle sclk rx_data", rx_data, m_rx);
    check("idle sclk rx_valid count", vcnt - v0, 0);

    cs = 1'b0;
    #100;
    xfer(16'h5555, 5, got);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    m_rx = '0;
    check("midrst rx_data", rx_data, 0);
    check("midrst miso", miso, 0);
    v0 = vcnt;
    xfer(16'hFFFF, 16, got);
    check("dead frame miso", got, 0);
    check("dead frame rx_valid count", vcnt - v0, 0);
    check("dead frame rx_data", rx_data, 0);
    #60 cs = 1'b1;
    #100;
    frame(16'h00FF, 16'h0000, 1, "postrst");

    for (int k = 0; k < 6; k++) begin
      nw = int'($urandom_range(2, 1));
      frame(16'($urandom), 16'($urandom), nw, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
